// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding, line level and index helper.
package uart_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} uart_tx_state_e;
    localparam logic UART_IDLE_LVL = 1'b1;
    function automatic int rr_mod(input int v, input int n);
        return v % n;
    endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick starting one past the last winner.
// Rotates req so that rr_ptr+1 sits at bit 0, priority-encodes, then unrotates the index.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_winner
);
    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_first;
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_rot[i] = i_req[IDX_W'(rr_mod(int'(i_rr_ptr) + 1 + i, NUM_REQ))];
        w_first = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_first = IDX_W'(i);
        o_any    = |i_req;
        o_winner = IDX_W'(rr_mod(int'(w_first) + int'(i_rr_ptr) + 1, NUM_REQ));
    end
endmodule

// File: rtl/uart_tx_rr_sched.sv
// uart_tx_rr_sched: round-robin shared 8N1 UART transmitter.
// Bit timing comes only from the external one-cycle baud_tick pulse.
module uart_tx_rr_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    uart_tx_state_e     r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_tx;
    logic               r_busy;
    logic               w_any;
    logic [IDX_W-1:0]   w_winner;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // A tick coinciding with the grant edge is dropped because IDLE never looks at baud_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
            r_owner   <= '0;
            r_gnt     <= '0;
            r_tx      <= UART_IDLE_LVL;
            r_busy    <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                TX_IDLE: if (w_any) begin
                    r_shift  <= data[int'(w_winner)*DATA_W +: DATA_W];
                    r_owner  <= w_winner;
                    r_rr_ptr <= w_winner;
                    r_gnt    <= NUM_REQ'(1) << w_winner;
                    r_busy   <= 1'b1;
                    r_state  <= TX_WAIT;
                end
                TX_WAIT: if (baud_tick) begin
                    r_tx    <= 1'b0;
                    r_state <= TX_START;
                end
                TX_START: if (baud_tick) begin
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= TX_DATA;
                end
                TX_DATA: if (baud_tick) begin
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        r_tx    <= UART_IDLE_LVL;
                        r_state <= TX_STOP;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: if (baud_tick) begin
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign tx    = r_tx;
    assign busy  = r_busy;
    assign owner = r_owner;
endmodule
